// File: rtl/spi_cmd_decoder_if.sv
// Receiver-side bus between the SPI byte receiver and the command decoder.
// All three signals originate outside the sysclk domain.
interface spi_cmd_decoder_if;
  logic       iRxReady;  // byte-ready strobe, SPI-clock domain
  logic [7:0] iRx;       // received byte, stable while the next byte shifts in
  logic       iSPICS;    // chip-select, active-low

  modport master (output iRxReady, output iRx, output iSPICS);
  modport slave  (input  iRxReady, input  iRx, input  iSPICS);
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: synchronises the receiver strobe and chip-select into
// sysclk, assembles 5-byte frames (header, cmd, addr, data, checksum),
// validates them, and drives the per-channel fan duty registers, an update
// strobe and a saturating frame-error counter.
module spi_cmd_decoder #(
  parameter int         NUM_CH         = 4,
  parameter logic [7:0] DUTY_RESET     = 8'h80,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] SYNC_HDR       = 8'hA5
) (
  input  logic                  sysclk,
  input  logic                  reset,
  spi_cmd_decoder_if.slave      rx_if,
  output logic [8*NUM_CH-1:0]   oDuty,
  output logic                  oUpdate,
  output logic [7:0]            oErrCount,
  output logic [2:0]            oState
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_SUM  = 3'd4;

  localparam logic [7:0] CMD_WR_ONE = 8'h01;
  localparam logic [7:0] CMD_WR_ALL = 8'h02;
  localparam logic [7:0] CMD_CLR_ERR = 8'h03;

  localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Synchroniser / edge-detect / byte capture registers
  logic        r_rdy_s1, r_rdy_s2, r_rdy_s3;
  logic        r_cs_s1, r_cs_s2, r_cs_s3;
  logic        r_byte_valid;
  logic [7:0]  r_byte;

  // Frame state
  logic [2:0]    r_state;
  logic [7:0]    r_cmd, r_addr, r_data;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_err;
  logic          r_update;
  logic [7:0]    r_duty [NUM_CH];

  // Decoded events for the current cycle
  logic w_rise;
  logic w_eval;
  logic w_sum_ok;
  logic w_wr_one;
  logic w_wr_all;
  logic w_clr;
  logic w_bad;
  logic w_busy;
  logic w_abort;
  logic w_tmo;

  // Two-flop synchroniser on the ready strobe, third flop for edge detection
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
      r_rdy_s3 <= 1'b0;
    end else begin
      r_rdy_s1 <= rx_if.iRxReady;
      r_rdy_s2 <= r_rdy_s1;
      r_rdy_s3 <= r_rdy_s2;
    end
  end

  assign w_rise = r_rdy_s2 & ~r_rdy_s3;

  // Register the byte-valid pulse and capture the byte alongside it; the byte
  // has been stable for several sysclks by the time the edge is seen
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
    end else begin
      r_byte_valid <= w_rise;
      if (w_rise) begin
        r_byte <= rx_if.iRx;
      end
    end
  end

  // Three-flop chip-select chain so CS lines up cycle-for-cycle with byte-valid
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_cs_s1 <= 1'b1;
      r_cs_s2 <= 1'b1;
      r_cs_s3 <= 1'b1;
    end else begin
      r_cs_s1 <= rx_if.iSPICS;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  // Frame evaluation happens when the checksum byte arrives in SUM. A byte
  // wins over a simultaneous CS abort, which in turn wins over the timeout.
  always_comb begin
    w_eval   = r_byte_valid && (r_state == ST_SUM);
    w_sum_ok = (r_byte == (r_cmd ^ r_addr ^ r_data));
    w_wr_one = w_eval && w_sum_ok && (r_cmd == CMD_WR_ONE) && (r_addr < 8'(NUM_CH));
    w_wr_all = w_eval && w_sum_ok && (r_cmd == CMD_WR_ALL);
    w_clr    = w_eval && w_sum_ok && (r_cmd == CMD_CLR_ERR);
    w_bad    = w_eval && !(w_wr_one || w_wr_all || w_clr);
    w_busy   = !r_byte_valid && (r_state != ST_IDLE);
    w_abort  = w_busy && r_cs_s3;
    w_tmo    = w_busy && !r_cs_s3 && (r_timer == TIMER_LAST);
  end

  // Frame FSM: header hunt in IDLE, then collect cmd/addr/data/checksum
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= 8'h00;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
    end else if (r_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte == SYNC_HDR) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          r_cmd   <= r_byte;
          r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          r_addr  <= r_byte;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_data  <= r_byte;
          r_state <= ST_SUM;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end else if (w_abort || w_tmo) begin
      r_state <= ST_IDLE;
    end
  end

  // Inter-byte timeout: runs only while a frame is in progress with no byte
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (r_byte_valid || (r_state == ST_IDLE) || w_abort || w_tmo) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Error counter: saturating increment; the clear command beats saturation
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_err <= 8'h00;
    end else if (w_clr) begin
      r_err <= 8'h00;
    end else if ((w_bad || w_abort || w_tmo) && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'h01;
    end
  end

  // Update strobe coincides with the edge on which the duty registers load
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_update <= 1'b0;
    end else begin
      r_update <= w_wr_one || w_wr_all;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_duty
      // Per-channel duty register, written by single-channel or broadcast cmd
      always_ff @(posedge sysclk) begin
        if (!reset) begin
          r_duty[gi] <= DUTY_RESET;
        end else if (w_wr_all || (w_wr_one && (r_addr == 8'(gi)))) begin
          r_duty[gi] <= r_data;
        end
      end

      assign oDuty[8*gi +: 8] = r_duty[gi];
    end
  endgenerate

  assign oUpdate   = r_update;
  assign oErrCount = r_err;
  assign oState    = r_state;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: a table of complete frames with
// hand-computed results, plus sequences for reset, CS abort, timeout,
// idle garbage, CS coinciding with the checksum byte and error saturation.
module tb_spi_cmd_decoder;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 100;

  logic        clk;
  logic        rst_n;
  logic [31:0] duty;
  logic        upd;
  logic [7:0]  err;
  logic [2:0]  st;

  spi_cmd_decoder_if rx_bus ();

  spi_cmd_decoder #(
    .NUM_CH         (NUM_CH),
    .DUTY_RESET     (8'h80),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SYNC_HDR       (8'hA5)
  ) dut (
    .sysclk    (clk),
    .reset     (rst_n),
    .rx_if     (rx_bus),
    .oDuty     (duty),
    .oUpdate   (upd),
    .oErrCount (err),
    .oState    (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every sysclk cycle on which oUpdate is high
  int upd_cycles = 0;
  always @(negedge clk) begin
    if (upd === 1'b1) upd_cycles++;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_bus.iRx      = b;
    rx_bus.iRxReady = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_bus.iRxReady = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b [5];
    logic [31:0] exp_duty;
    logic [7:0]  exp_err;
    int          exp_upd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int upd0;
    int n;
    logic [7:0] err0;

    vecs[0] = '{"wr_ch2",        '{8'hA5, 8'h01, 8'h02, 8'h3F, 8'h3C}, 32'h803F8080, 8'd0, 1};
    vecs[1] = '{"wr_all_ff",     '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFD}, 32'hFFFFFFFF, 8'd0, 1};
    vecs[2] = '{"addr_oob",      '{8'hA5, 8'h01, 8'h04, 8'h10, 8'h15}, 32'hFFFFFFFF, 8'd1, 0};
    vecs[3] = '{"bad_sum",       '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00}, 32'hFFFFFFFF, 8'd2, 0};
    vecs[4] = '{"clr_err",       '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h03}, 32'hFFFFFFFF, 8'd0, 0};
    vecs[5] = '{"unknown_cmd",   '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h07}, 32'hFFFFFFFF, 8'd1, 0};
    vecs[6] = '{"hdr_as_data",   '{8'hA5, 8'h01, 8'h03, 8'hA5, 8'hA7}, 32'hA5FFFFFF, 8'd1, 1};
    vecs[7] = '{"wr_ch0",        '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h13}, 32'hA5FFFF12, 8'd1, 1};
    vecs[8] = '{"wr_same_value", '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h13}, 32'hA5FFFF12, 8'd1, 1};

    rx_bus.iRxReady = 1'b0;
    rx_bus.iRx      = 8'h00;
    rx_bus.iSPICS   = 1'b0;
    rst_n           = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and quiet idle
    repeat (20) @(negedge clk);
    check("reset_duty",  duty, 32'h80808080);
    check("reset_err",   err, 8'd0);
    check("reset_state", st, 3'd0);
    check("reset_no_upd", upd_cycles, 0);

    // Table of complete frames
    foreach (vecs[i]) begin
      upd0 = upd_cycles;
      send_frame(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3], vecs[i].b[4]);
      repeat (2) @(negedge clk);
      check({vecs[i].name, "_duty"},  duty, vecs[i].exp_duty);
      check({vecs[i].name, "_err"},   err, vecs[i].exp_err);
      check({vecs[i].name, "_upd"},   upd_cycles - upd0, vecs[i].exp_upd);
      check({vecs[i].name, "_state"}, st, 3'd0);
    end

    // CS abort mid-frame, then a clean frame
    err0 = err;
    send_byte(8'hA5);
    send_byte(8'h01);
    @(negedge clk);
    check("abort_pre_state", st, 3'd2);
    #1 rx_bus.iSPICS = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_state", st, 3'd0);
    check("abort_err",   err, err0 + 8'd1);
    rx_bus.iSPICS = 1'b0;
    repeat (4) @(posedge clk);
    send_frame(8'hA5, 8'h01, 8'h01, 8'h55, 8'h55);
    repeat (2) @(negedge clk);
    check("post_abort_duty", duty, 32'hA5FF5512);

    // Idle garbage bytes do not count as errors
    err0 = err;
    send_byte(8'h00);
    send_byte(8'h7E);
    @(negedge clk);
    check("idle_garbage_err",   err, err0);
    check("idle_garbage_state", st, 3'd0);

    // Timeout: exactly TIMEOUT cycles in ADDR after the cmd byte is taken
    send_byte(8'hA5);
    @(posedge clk); #1;
    rx_bus.iRx = 8'h01;
    rx_bus.iRxReady = 1'b1;
    n = 0;
    while (st !== 3'd2 && n < 50) begin
      @(negedge clk); n++;
    end
    check("tmo_reach_addr", st, 3'd2);
    rx_bus.iRxReady = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (st !== 3'd0 && n < 500);
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_err", err, err0 + 8'd1);

    // Checksum byte arriving together with CS high still completes
    err0 = err;
    upd0 = upd_cycles;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h33);
    @(posedge clk); #1;
    rx_bus.iRx      = 8'h31;
    rx_bus.iRxReady = 1'b1;
    rx_bus.iSPICS   = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_bus.iRxReady = 1'b0;
    repeat (6) @(negedge clk);
    check("cs_sum_duty",  duty, 32'h33333333);
    check("cs_sum_err",   err, err0);
    check("cs_sum_upd",   upd_cycles - upd0, 1);
    check("cs_sum_state", st, 3'd0);
    rx_bus.iSPICS = 1'b0;
    repeat (4) @(posedge clk);

    // Saturation via repeated CS aborts, then clear overrides it
    for (int k = 0; k < 260; k++) begin
      send_byte(8'hA5);
      #1 rx_bus.iSPICS = 1'b1;
      repeat (6) @(posedge clk);
      #1 rx_bus.iSPICS = 1'b0;
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    check("sat_err", err, 8'd255);
    send_frame(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03);
    repeat (2) @(negedge clk);
    check("sat_clear_err", err, 8'd0);

    // Mid-frame reset discards the frame and restores reset values
    send_frame(8'hA5, 8'h01, 8'h00, 8'h20, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h02);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_duty",  duty, 32'h80808080);
    check("midrst_err",   err, 8'd0);
    check("midrst_state", st, 3'd0);
    check("midrst_upd",   upd, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
